// File: rtl/mst_rd_arbiter_if.sv
// Bundle of the two read clients and the shared IPIF master-burst read channel.
// The arbiter uses the master modport; clients and the bus model use slave.
interface mst_rd_arbiter_if;
  logic        c0_req,       c1_req;
  logic [31:0] c0_addr,      c1_addr;
  logic [11:0] c0_len,       c1_len;
  logic        c0_dst_rdy_n, c1_dst_rdy_n;
  logic        c0_cmdack,    c1_cmdack;
  logic        c0_src_rdy_n, c1_src_rdy_n;
  logic        c0_cmplt,     c1_cmplt;
  logic        c0_error,     c1_error;

  logic        ip2bus_mstrd_req;
  logic        ip2bus_mst_type;
  logic [31:0] ip2bus_mst_addr;
  logic [11:0] ip2bus_mst_length;
  logic        ip2bus_mstrd_dst_rdy_n;
  logic        bus2ip_mst_cmdack;
  logic        bus2ip_mst_cmplt;
  logic        bus2ip_mst_error;
  logic        bus2ip_mstrd_src_rdy_n;

  modport master (
    input  c0_req, c1_req, c0_addr, c1_addr, c0_len, c1_len, c0_dst_rdy_n, c1_dst_rdy_n,
    output c0_cmdack, c1_cmdack, c0_src_rdy_n, c1_src_rdy_n,
    output c0_cmplt, c1_cmplt, c0_error, c1_error,
    output ip2bus_mstrd_req, ip2bus_mst_type, ip2bus_mst_addr, ip2bus_mst_length,
    output ip2bus_mstrd_dst_rdy_n,
    input  bus2ip_mst_cmdack, bus2ip_mst_cmplt, bus2ip_mst_error, bus2ip_mstrd_src_rdy_n
  );

  modport slave (
    output c0_req, c1_req, c0_addr, c1_addr, c0_len, c1_len, c0_dst_rdy_n, c1_dst_rdy_n,
    input  c0_cmdack, c1_cmdack, c0_src_rdy_n, c1_src_rdy_n,
    input  c0_cmplt, c1_cmplt, c0_error, c1_error,
    input  ip2bus_mstrd_req, ip2bus_mst_type, ip2bus_mst_addr, ip2bus_mst_length,
    input  ip2bus_mstrd_dst_rdy_n,
    output bus2ip_mst_cmdack, bus2ip_mst_cmplt, bus2ip_mst_error, bus2ip_mstrd_src_rdy_n
  );
endinterface

// File: rtl/mst_rd_arbiter.sv
// Two-client arbiter for the single master-burst read channel; client 0 has priority,
// client 1 is forced after MAX_CONSEC back-to-back client-0 wins. Watchdog: ARB_TIMEOUT_EN.
module mst_rd_arbiter #(
  parameter int MAX_CONSEC     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             reset,
  mst_rd_arbiter_if.master bus,
  output logic [1:0]       grant,
  output logic [11:0]      beat_count,
  output logic             timeout_flag
);
  localparam int CW = $clog2(MAX_CONSEC + 1);

  typedef enum logic [1:0] {IDLE, CMD, XFER, DONE} state_e;

  state_e        state_q, state_d;
  logic [1:0]    grant_q, grant_d;
  logic [31:0]   addr_q, addr_d;
  logic [11:0]   len_q, len_d;
  logic [11:0]   beat_q, beat_d;
  logic [CW-1:0] consec_q, consec_d;

  logic in_cmd, in_xfer, sel_dst_n, win1;
  logic cmdack_hit, beat_hit, cmplt_hit, timeout_hit, end_hit;

  assign in_cmd     = (state_q == CMD);
  assign in_xfer    = (state_q == XFER);
  assign sel_dst_n  = grant_q[1] ? bus.c1_dst_rdy_n : bus.c0_dst_rdy_n;
  assign cmdack_hit = in_cmd & bus.bus2ip_mst_cmdack;
  assign beat_hit   = in_xfer & ~sel_dst_n & ~bus.bus2ip_mstrd_src_rdy_n;
  // A completion arriving together with cmdack in CMD is honoured as well.
  assign cmplt_hit  = (in_xfer | cmdack_hit) & bus.bus2ip_mst_cmplt;
  assign end_hit    = cmplt_hit | timeout_hit;
  assign win1       = bus.c1_req & (~bus.c0_req | (consec_q == CW'(MAX_CONSEC)));

  assign bus.ip2bus_mstrd_req       = in_cmd;
  assign bus.ip2bus_mst_type        = in_cmd;
  assign bus.ip2bus_mst_addr        = addr_q;
  assign bus.ip2bus_mst_length      = len_q;
  assign bus.ip2bus_mstrd_dst_rdy_n = in_xfer ? sel_dst_n : 1'b1;

  assign bus.c0_cmdack    = cmdack_hit & grant_q[0];
  assign bus.c1_cmdack    = cmdack_hit & grant_q[1];
  assign bus.c0_src_rdy_n = ~(in_xfer & grant_q[0]) | bus.bus2ip_mstrd_src_rdy_n;
  assign bus.c1_src_rdy_n = ~(in_xfer & grant_q[1]) | bus.bus2ip_mstrd_src_rdy_n;
  assign bus.c0_cmplt     = end_hit & grant_q[0];
  assign bus.c1_cmplt     = end_hit & grant_q[1];
  assign bus.c0_error     = ((cmplt_hit & bus.bus2ip_mst_error) | timeout_hit) & grant_q[0];
  assign bus.c1_error     = ((cmplt_hit & bus.bus2ip_mst_error) | timeout_hit) & grant_q[1];

  assign grant      = grant_q;
  assign beat_count = beat_q;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    addr_d   = addr_q;
    len_d    = len_q;
    beat_d   = beat_q;
    consec_d = consec_q;
    case (state_q)
      IDLE: begin
        if (bus.c0_req | bus.c1_req) begin
          grant_d = win1 ? 2'b10 : 2'b01;
          addr_d  = win1 ? bus.c1_addr : bus.c0_addr;
          len_d   = win1 ? bus.c1_len  : bus.c0_len;
          beat_d  = '0;
          state_d = CMD;
          if (win1 | ~bus.c1_req)
            consec_d = '0;
          else if (consec_q != CW'(MAX_CONSEC))
            consec_d = consec_q + 1'b1;
        end
      end
      CMD: begin
        if (end_hit) begin
          state_d = DONE;
          grant_d = 2'b00;
        end else if (cmdack_hit) begin
          state_d = XFER;
        end
      end
      XFER: begin
        if (beat_hit) beat_d = beat_q + 12'd1;
        if (end_hit) begin
          state_d = DONE;
          grant_d = 2'b00;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      grant_q  <= 2'b00;
      addr_q   <= '0;
      len_q    <= '0;
      beat_q   <= '0;
      consec_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      beat_q   <= beat_d;
      consec_q <= consec_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  logic [WW-1:0] wd_q, wd_d;
  logic          flag_q, flag_d;
  logic          stalled;

  // Progress is either a command ack or an accepted beat; anything else is a stall cycle.
  assign stalled     = (in_cmd | in_xfer) & ~cmdack_hit & ~beat_hit;
  assign timeout_hit = stalled & (wd_q == WW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wd_d   = '0;
    flag_d = flag_q | timeout_hit;
    if (stalled & ~end_hit) wd_d = wd_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_q   <= '0;
      flag_q <= 1'b0;
    end else begin
      wd_q   <= wd_d;
      flag_q <= flag_d;
    end
  end

  assign timeout_flag = flag_q;
`else
  // No watchdog: the flag can never be set.
  assign timeout_hit  = 1'b0;
  assign timeout_flag = (TIMEOUT_CYCLES < 0);
`endif
endmodule

// File: tb/tb_mst_rd_arbiter.sv
// Directed + randomized bench for mst_rd_arbiter with a rule-level arbitration model
// and a beat-counting master/client model.
module tb_mst_rd_arbiter;
  localparam int MAXC = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  grant;
  logic [11:0] beat_count;
  logic        timeout_flag;

  int n_cmp = 0;
  int n_bad = 0;
  int run   = 0;  // client-0 wins in a row while client 1 waited
  int order [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

  mst_rd_arbiter_if bif ();

  mst_rd_arbiter #(.MAX_CONSEC(MAXC), .TIMEOUT_CYCLES(16)) dut (
    .clk          (clk),
    .reset        (rst_n),
    .bus          (bif.master),
    .grant        (grant),
    .beat_count   (beat_count),
    .timeout_flag (timeout_flag)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference arbitration rule: c0 wins unless c1 is alone or c1 has waited MAXC c0 wins.
  function automatic int arb(input bit r0, input bit r1);
    int w;
    w = (r1 && (!r0 || run == MAXC)) ? 1 : 0;
    if (w == 0 && r1) run = (run < MAXC) ? run + 1 : run;
    else              run = 0;
    return w;
  endfunction

  task automatic set_req(input int cl, input bit r);
    if (cl == 0) bif.c0_req = r;
    else         bif.c1_req = r;
  endtask

  task automatic set_client(input int cl, input bit r, input logic [31:0] a, input logic [11:0] l);
    if (cl == 0) begin bif.c0_req = r; bif.c0_addr = a; bif.c0_len = l; end
    else         begin bif.c1_req = r; bif.c1_addr = a; bif.c1_len = l; end
  endtask

  // Called at an IDLE negedge; returns at the IDLE negedge after the burst's DONE cycle.
  // mode 0: no stalls, 1: granted dst toggles (starting high), 2: random handshakes.
  task automatic do_burst(input int cl, input logic [31:0] ea, input logic [11:0] el,
                          input int nbeats, input int ack_dly, input bit err,
                          input int mode, input bit drop);
    logic [1:0] oh;
    int lat, beats, cyc;
    bit s, d;
    oh  = (cl == 1) ? 2'b10 : 2'b01;
    lat = 0;
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      @(negedge clk); #1;
      if (bif.ip2bus_mstrd_req === 1'b1) lat = i;
    end
    chk("req_latency", lat, 1);
    if (lat == 0) return;
    chk("grant", grant, oh);
    chk("mst_addr", bif.ip2bus_mst_addr, ea);
    chk("mst_len", bif.ip2bus_mst_length, el);
    chk("mst_type", bif.ip2bus_mst_type, 1);
    for (int i = 0; i < ack_dly; i++) begin
      chk("cmd_no_ack", {bif.c1_cmdack, bif.c0_cmdack}, 0);
      chk("cmd_no_cmplt", {bif.c1_cmplt, bif.c0_cmplt}, 0);
      chk("cmd_dst_rdy", bif.ip2bus_mstrd_dst_rdy_n, 1);
      @(negedge clk); #1;
    end
    bif.bus2ip_mst_cmdack = 1'b1; #1;
    chk("cmdack", {bif.c1_cmdack, bif.c0_cmdack}, oh);
    if (drop) set_req(cl, 1'b0);
    @(negedge clk);
    bif.bus2ip_mst_cmdack = 1'b0;
    beats = 0;
    cyc   = 0;
    while (beats < nbeats && cyc < 3000) begin
      s = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      d = (mode == 1) ? (cyc % 2 == 0) : (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      bif.bus2ip_mstrd_src_rdy_n = s;
      if (cl == 1) begin bif.c1_dst_rdy_n = d; bif.c0_dst_rdy_n = 1'($urandom_range(0, 1)); end
      else         begin bif.c0_dst_rdy_n = d; bif.c1_dst_rdy_n = 1'($urandom_range(0, 1)); end
      #1;
      chk("xfer_grant", grant, oh);
      chk("dst_fwd", bif.ip2bus_mstrd_dst_rdy_n, d);
      chk("src_route", {bif.c1_src_rdy_n, bif.c0_src_rdy_n}, (cl == 1) ? {s, 1'b1} : {1'b1, s});
      chk("beat_run", beat_count, beats);
      chk("xfer_no_cmplt", {bif.c1_cmplt, bif.c0_cmplt}, 0);
      if (!s && !d) beats++;
      cyc++;
      @(negedge clk);
    end
    chk("xfer_bound", (cyc < 3000), 1);
    bif.bus2ip_mstrd_src_rdy_n = 1'b1;
    bif.c0_dst_rdy_n = 1'b1;
    bif.c1_dst_rdy_n = 1'b1;
    bif.bus2ip_mst_cmplt = 1'b1;
    bif.bus2ip_mst_error = err;
    #1;
    chk("cmplt", {bif.c1_cmplt, bif.c0_cmplt}, oh);
    chk("error", {bif.c1_error, bif.c0_error}, err ? oh : 2'b00);
    @(negedge clk);
    bif.bus2ip_mst_cmplt = 1'b0;
    bif.bus2ip_mst_error = 1'b0;
    #1;
    chk("done_grant", grant, 0);
    chk("done_req", bif.ip2bus_mstrd_req, 0);
    chk("done_dst", bif.ip2bus_mstrd_dst_rdy_n, 1);
    chk("beat_count", beat_count, nbeats);
    @(negedge clk);
    bif.bus2ip_mst_cmplt = 1'b1;
    bif.bus2ip_mst_error = 1'b1;
    #1;
    chk("stray_cmplt", {bif.c1_cmplt, bif.c0_cmplt}, 0);
    chk("stray_error", {bif.c1_error, bif.c0_error}, 0);
    chk("idle_req", bif.ip2bus_mstrd_req, 0);
    bif.bus2ip_mst_cmplt = 1'b0;
    bif.bus2ip_mst_error = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    set_client(0, 1'b0, 32'h0, 12'h0);
    set_client(1, 1'b0, 32'h0, 12'h0);
    bif.c0_dst_rdy_n = 1'b1;
    bif.c1_dst_rdy_n = 1'b1;
    bif.bus2ip_mst_cmdack = 1'b0;
    bif.bus2ip_mst_cmplt = 1'b0;
    bif.bus2ip_mst_error = 1'b0;
    bif.bus2ip_mstrd_src_rdy_n = 1'b1;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_req", bif.ip2bus_mstrd_req, 0);
    chk("rst_type", bif.ip2bus_mst_type, 0);
    chk("rst_addr", bif.ip2bus_mst_addr, 0);
    chk("rst_len", bif.ip2bus_mst_length, 0);
    chk("rst_dst", bif.ip2bus_mstrd_dst_rdy_n, 1);
    chk("rst_beat", beat_count, 0);
    chk("rst_src", {bif.c1_src_rdy_n, bif.c0_src_rdy_n}, 2'b11);
    chk("rst_flag", timeout_flag, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // c0 alone, full-rate 124-beat burst
    set_client(0, 1'b1, 32'h1000_0000, 12'd496);
    void'(arb(1'b1, 1'b0));
    do_burst(0, 32'h1000_0000, 12'd496, 124, 1, 1'b0, 0, 1'b1);

    // c1 with toggling dst_rdy_n
    set_client(1, 1'b1, 32'h1000_4000, 12'd40);
    void'(arb(1'b0, 1'b1));
    do_burst(1, 32'h1000_4000, 12'd40, 10, 0, 1'b0, 1, 1'b1);

    // c0 burst ending in error
    set_client(0, 1'b1, 32'h1000_8000, 12'd16);
    void'(arb(1'b1, 1'b0));
    do_burst(0, 32'h1000_8000, 12'd16, 4, 2, 1'b1, 2, 1'b1);

`ifndef ARB_TIMEOUT_EN
    // long wait for cmdack must not end the burst
    set_client(0, 1'b1, 32'h1000_C000, 12'd12);
    void'(arb(1'b1, 1'b0));
    do_burst(0, 32'h1000_C000, 12'd12, 3, 40, 1'b0, 0, 1'b1);
`endif

    // async reset in the middle of a transfer
    set_client(0, 1'b1, 32'h3000_0000, 12'd32);
    @(negedge clk); #1;
    chk("mr_cmd", bif.ip2bus_mstrd_req, 1);
    bif.bus2ip_mst_cmdack = 1'b1;
    set_req(0, 1'b0);
    @(negedge clk);
    bif.bus2ip_mst_cmdack = 1'b0;
    bif.bus2ip_mstrd_src_rdy_n = 1'b0;
    bif.c0_dst_rdy_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bif.bus2ip_mst_cmplt = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("mr_grant", grant, 0);
    chk("mr_beat", beat_count, 0);
    chk("mr_cmplt", {bif.c1_cmplt, bif.c0_cmplt}, 0);
    chk("mr_src", {bif.c1_src_rdy_n, bif.c0_src_rdy_n}, 2'b11);
    chk("mr_dst", bif.ip2bus_mstrd_dst_rdy_n, 1);
    chk("mr_addr", bif.ip2bus_mst_addr, 0);
    chk("mr_req", bif.ip2bus_mstrd_req, 0);
    bif.bus2ip_mst_cmplt = 1'b0;
    bif.bus2ip_mstrd_src_rdy_n = 1'b1;
    bif.c0_dst_rdy_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    run = 0;

    // both clients requesting continuously: fairness pattern
    set_client(0, 1'b1, 32'hA000_0000, 12'd8);
    set_client(1, 1'b1, 32'hB000_0000, 12'd8);
    for (int k = 0; k < 10; k++) begin
      void'(arb(1'b1, 1'b1));
      do_burst(order[k], (order[k] == 1) ? 32'hB000_0000 : 32'hA000_0000, 12'd8,
               2, 0, 1'b0, 2, 1'b0);
    end
    set_req(0, 1'b0);
    set_req(1, 1'b0);

    // randomized request patterns against the rule model
    for (int k = 0; k < 12; k++) begin
      bit r0, r1;
      int w;
      logic [31:0] a0, a1;
      logic [11:0] l0, l1;
      r0 = bif.c0_req | 1'($urandom_range(0, 1));
      r1 = bif.c1_req | 1'($urandom_range(0, 1));
      if (!r0 && !r1) r0 = 1'b1;
      a0 = $urandom;
      a1 = $urandom;
      l0 = 12'($urandom);
      l1 = 12'($urandom);
      set_client(0, r0, a0, l0);
      set_client(1, r1, a1, l1);
      w = arb(r0, r1);
      do_burst(w, (w == 1) ? a1 : a0, (w == 1) ? l1 : l0, $urandom_range(1, 12),
               $urandom_range(0, 3), 1'($urandom_range(0, 1)), 2, 1'b1);
    end
    set_req(0, 1'b0);
    set_req(1, 1'b0);

`ifdef ARB_TIMEOUT_EN
    // watchdog: no cmdack for 16 cycles
    set_client(0, 1'b1, 32'h2000_0000, 12'd64);
    void'(arb(1'b1, 1'b0));
    @(negedge clk); #1;
    chk("wd_cmd", bif.ip2bus_mstrd_req, 1);
    for (int i = 1; i < 16; i++) begin
      chk("wd_quiet", {bif.c1_cmplt, bif.c0_cmplt}, 0);
      @(negedge clk); #1;
    end
    chk("wd_cmplt", {bif.c1_cmplt, bif.c0_cmplt}, 2'b01);
    chk("wd_error", {bif.c1_error, bif.c0_error}, 2'b01);
    set_req(0, 1'b0);
    @(negedge clk); #1;
    chk("wd_flag", timeout_flag, 1);
    chk("wd_done_grant", grant, 0);
    @(negedge clk); #1;
`endif

    set_client(1, 1'b1, 32'h4000_0000, 12'd12);
    void'(arb(1'b0, 1'b1));
    do_burst(1, 32'h4000_0000, 12'd12, 3, 0, 1'b0, 0, 1'b1);
`ifdef ARB_TIMEOUT_EN
    chk("wd_sticky", timeout_flag, 1);
`else
    chk("flag_tied", timeout_flag, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
